pipe_stage_buf: RTL and testbench

Parametrised pipeline-stage register with a valid/ready handshake, synchronous flush and stall accounting. It replaces the free-running stage registers between fetch, decode, execute/dmem and writeback, so any stage can back-pressure its predecessor without losing data. One instance sits on each stage boundary, carrying that boundary's packed payload as an opaque WIDTH-bit vector.

---
 rtl/pipe_stage_buf.sv | 60 ++++++
 tb/tb_pipe_stage_buf.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: valid/ready pipeline stage register with flush and saturating stall counter.
// Define PIPE_SKID_EN for a two-entry skid stage with registered in_ready; default is single-register.
module pipe_stage_buf #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] main_q;
  logic in_fire, out_fire;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign out_data = main_q;
  always_ff @(posedge CLK)
    if (RST) state <= EMPTY;
    else     state <= state_nxt;
  always_comb
    state_nxt = flush           ? EMPTY :
                state == EMPTY  ? (in_fire ? ONE : EMPTY) :
                state == ONE    ? (in_fire && !out_fire ? FULL :
                                   !in_fire && out_fire ? EMPTY : ONE) :
                                  (out_fire ? ONE : FULL);
  // State encoding doubles as the entry count.
  always_comb begin
    out_valid = state != EMPTY;
    occupancy = state;
`ifdef PIPE_SKID_EN
    in_ready  = !RST && state != FULL;
`else
    in_ready  = !RST && (state == EMPTY || out_ready);
`endif
  end
`ifdef PIPE_SKID_EN
  logic [WIDTH-1:0] skid_q;
  always_ff @(posedge CLK)
    if (RST) skid_q <= '0;
    else if (!flush && state == ONE && in_fire && !out_fire) skid_q <= in_data;
`endif
  always_ff @(posedge CLK)
    if (RST) main_q <= '0;
    else if (!flush && in_fire && (state == EMPTY || out_fire)) main_q <= in_data;
`ifdef PIPE_SKID_EN
    else if (!flush && state == FULL && out_fire) main_q <= skid_q;
`endif
  always_ff @(posedge CLK)
    if (RST) stall_cnt <= '0;
    else if (out_valid && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed and randomized checks of pipe_stage_buf against a queue-based model.
module tb_pipe_stage_buf;
  localparam int W  = 8;
  localparam int CW = 3;
`ifdef PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  localparam logic [CW-1:0] SMAX = '1;
  logic CLK = 1'b0, RST = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid;
  logic [W-1:0] in_data = '0, out_data;
  logic [1:0] occupancy;
  logic [CW-1:0] stall_cnt;
  int total = 0, bad = 0;
  logic [W-1:0] mq[$];
  logic [CW-1:0] m_stall = '0;

  pipe_stage_buf #(.WIDTH(W), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  // Model: the stage is a FIFO of capacity 2 (skid) or 1 (plain, with pass-through when draining).
  function automatic bit m_ready();
    return !RST && (SKID ? mq.size() < 2 : (mq.size() == 0 || out_ready));
  endfunction

  always @(posedge CLK) begin
    bit ir, ov;
    ir = m_ready();
    ov = mq.size() > 0;
    if (RST) begin
      mq.delete();
      m_stall <= '0;
    end else begin
      if (ov && !out_ready && m_stall != SMAX) m_stall <= m_stall + 1'b1;
      if (flush) mq.delete();
      else begin
        if (ov && out_ready) void'(mq.pop_front());
        if (in_valid && ir) mq.push_back(in_data);
      end
    end
  end

  task automatic test_reset();
    RST = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 || occupancy !== 2'd0 || stall_cnt !== '0) begin
      bad++;
      $display("FAIL reset_values: ir=%b ov=%b od=%h occ=%0d st=%0d, want all zero", in_ready, out_valid, out_data, occupancy, stall_cnt);
    end
    @(negedge CLK);
    RST = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_reset: in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_streaming();
    logic [W-1:0] vals[3] = '{8'h11, 8'h22, 8'h33};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      in_valid = i < 3;
      in_data  = i < 3 ? vals[i] : '0;
      #1;
      if (i > 0) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== vals[i-1] || occupancy !== 2'd1 || stall_cnt !== '0) begin
          bad++;
          $display("FAIL streaming[%0d]: ov=%b od=%h occ=%0d st=%0d want ov=1 od=%h occ=1 st=0", i, out_valid, out_data, occupancy, stall_cnt, vals[i-1]);
        end
      end
    end
    @(negedge CLK);
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] src[$];
    logic [W-1:0] got[$];
    src = '{8'hA0, 8'hA1, 8'hA2};
    @(negedge CLK);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 30 && (src.size() > 0 || got.size() < 3); c++) begin
      @(negedge CLK);
      out_ready = !(c >= 1 && c <= 5);
      in_valid  = src.size() > 0;
      in_data   = src.size() > 0 ? src[0] : '0;
      #1;
      if (c == 4) begin
        total++;
        if (out_data !== 8'hA0 || out_valid !== 1'b1 || in_ready !== 1'b0 || occupancy !== (SKID ? 2'd2 : 2'd1) || stall_cnt !== m_stall) begin
          bad++;
          $display("FAIL backpressure_hold: od=%h ov=%b ir=%b occ=%0d st=%0d want od=a0 ov=1 ir=0 occ=%0d st=%0d", out_data, out_valid, in_ready, occupancy, stall_cnt, SKID ? 2 : 1, m_stall);
        end
      end
      if (out_valid && out_ready) got.push_back(out_data);
      if (in_valid && in_ready) void'(src.pop_front());
    end
    total++;
    if (got.size() != 3 || got[0] !== 8'hA0 || got[1] !== 8'hA1 || got[2] !== 8'hA2) begin
      bad++;
      $display("FAIL backpressure_order: got %0d items %p want a0 a1 a2", got.size(), got);
    end
    @(negedge CLK);
    in_valid = 1'b0;
  endtask

  task automatic test_flush();
    @(negedge CLK);
    flush = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge CLK);
    flush = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h31;
    @(negedge CLK);
    in_valid = SKID; in_data = 8'h32;
    @(negedge CLK);
    in_valid = 1'b0;
    #1;
    total++;
    if (occupancy !== (SKID ? 2'd2 : 2'd1)) begin
      bad++;
      $display("FAIL flush_fill: occ=%0d want %0d", occupancy, SKID ? 2 : 1);
    end
    @(negedge CLK);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
    @(negedge CLK);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL flush_empty: ov=%b occ=%0d ir=%b want ov=0 occ=0 ir=1", out_valid, occupancy, in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      #1;
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL flush_no_ghost[%0d]: ov=%b od=%h want ov=0", i, out_valid, out_data);
      end
    end
  endtask

  task automatic test_stall_sat();
    @(negedge CLK);
    RST = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge CLK);
    RST = 1'b0; in_valid = 1'b1; in_data = 8'h77;
    for (int i = 0; i <= 10; i++) begin
      @(negedge CLK);
      in_valid = 1'b0;
      #1;
      total++;
      if (stall_cnt !== CW'(i > 7 ? 7 : i) || out_data !== 8'h77) begin
        bad++;
        $display("FAIL stall_count[%0d]: st=%0d od=%h want st=%0d od=77", i, stall_cnt, out_data, i > 7 ? 7 : i);
      end
    end
    @(negedge CLK);
    flush = 1'b1;
    @(negedge CLK);
    flush = 1'b0;
    #1;
    total++;
    if (stall_cnt !== 3'd7 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL stall_after_flush: st=%0d ov=%b want st=7 ov=0", stall_cnt, out_valid);
    end
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    #1;
    total++;
    if (stall_cnt !== 3'd0) begin
      bad++;
      $display("FAIL stall_after_reset: st=%0d want 0", stall_cnt);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge CLK);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h41;
    @(negedge CLK);
    in_valid = SKID; in_data = 8'h42;
    @(negedge CLK);
    RST = 1'b1; in_valid = 1'b1; in_data = 8'h99;
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL ready_in_reset: ir=%b want 0", in_ready);
    end
    @(negedge CLK);
    RST = 1'b0; in_valid = 1'b1; in_data = 8'h05;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== '0 || occupancy !== 2'd0 || stall_cnt !== '0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid: ov=%b od=%h occ=%0d st=%0d ir=%b want 0 0 0 0 ir=1", out_valid, out_data, occupancy, stall_cnt, in_ready);
    end
    @(negedge CLK);
    in_valid = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'h05) begin
      bad++;
      $display("FAIL reset_mid_first: ov=%b od=%h want ov=1 od=05", out_valid, out_data);
    end
  endtask

  task automatic test_random(input int n, input bit toggle);
    bit hold = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(negedge CLK);
      if (!hold) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = W'($urandom);
      end
      out_ready = toggle ? c[0] : ($urandom_range(0, 3) != 0);
      flush     = !toggle && $urandom_range(0, 19) == 0;
      RST       = !toggle && $urandom_range(0, 99) == 0;
      #1;
      total++;
      if (in_ready !== m_ready() || out_valid !== (mq.size() > 0) || occupancy !== 2'(mq.size()) || stall_cnt !== m_stall) begin
        bad++;
        $display("FAIL random_ctrl[%0d]: ir=%b ov=%b occ=%0d st=%0d want ir=%b ov=%b occ=%0d st=%0d",
                 c, in_ready, out_valid, occupancy, stall_cnt, m_ready(), mq.size() > 0, mq.size(), m_stall);
      end
      if (mq.size() > 0) begin
        total++;
        if (out_data !== mq[0]) begin
          bad++;
          $display("FAIL random_data[%0d]: od=%h want %h", c, out_data, mq[0]);
        end
      end
      hold = in_valid && !in_ready;
    end
    @(negedge CLK);
    RST = 1'b0; flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_stall_sat();
    test_reset_mid();
    test_random(400, 1'b0);
    test_random(60, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
